// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and the pipeline-control state type.
// Latency: none (constants and types only).
// Backpressure: not applicable.
package y86_pkg;

   // Status codes carried down the pipe
   localparam logic [1:0] STAT_AOK = 2'd0;
   localparam logic [1:0] STAT_HLT = 2'd1;
   localparam logic [1:0] STAT_ADR = 2'd2;
   localparam logic [1:0] STAT_INS = 2'd3;

   // Instruction codes
   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_CMOVXX = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   // "No register" ID
   localparam logic [3:0] RNONE = 4'hF;

   typedef enum logic [1:0] {
      INIT   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } ctrl_state_t;

endpackage

// File: rtl/pipe_hazard_detect.sv
// Hazard classification for the Y86-64 pipe: load-use, mispredict, ret pending, exception.
// Latency: purely combinational, zero cycles.
// Backpressure: none; results feed the stall/bubble muxing in pipe_ctrl.
module pipe_hazard_detect
   import y86_pkg::*;
(
   input  logic [3:0] D_icode,
   input  logic [3:0] d_srcA,
   input  logic [3:0] d_srcB,
   input  logic [3:0] E_icode,
   input  logic [3:0] E_dstM,
   input  logic       e_cnd,
   input  logic [3:0] M_icode,
   input  logic [1:0] m_stat,
   input  logic [1:0] W_stat,
   output logic       load_use,
   output logic       mispred,
   output logic       ret_pend,
   output logic       exc
);

   // Classify the current pipeline contents into the four hazard terms
   always_comb begin
      load_use = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
                 (E_dstM != RNONE) &&
                 ((E_dstM == d_srcA) || (E_dstM == d_srcB));
      // Branches are predicted taken, so a not-taken jXX in E is a mispredict
      mispred  = (E_icode == I_JXX) && !e_cnd;
      ret_pend = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
      exc      = (m_stat != STAT_AOK) || (W_stat != STAT_AOK);
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control: post-reset flush, per-stage stall/bubble, set_cc, terminal halt.
// Latency: controls are combinational from state and inputs; state changes on the next clk edge.
// Backpressure: stalls hold upstream stages; perf counters (PIPE_CTRL_PERF_EN) count RUN cycles only.
module pipe_ctrl
   import y86_pkg::*;
#(
   parameter int FLUSH_CYCLES = 5,
   parameter int CNT_W        = 32
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       D_icode,
   input  logic [3:0]       d_srcA,
   input  logic [3:0]       d_srcB,
   input  logic [3:0]       E_icode,
   input  logic [3:0]       E_dstM,
   input  logic             e_cnd,
   input  logic [3:0]       M_icode,
   input  logic [1:0]       m_stat,
   input  logic [1:0]       W_stat,
   output logic             F_stall,
   output logic             D_stall,
   output logic             D_bubble,
   output logic             E_bubble,
   output logic             M_bubble,
   output logic             W_stall,
   output logic             W_bubble,
   output logic             set_cc,
   output logic             halted,
   output logic [1:0]       halt_stat,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] bubble_cnt
);

   localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

   ctrl_state_t   state_q, state_d;
   logic [FW-1:0] flush_cnt_q, flush_cnt_d;
   logic [1:0]    halt_stat_q, halt_stat_d;

   logic load_use, mispred, ret_pend, exc;

   pipe_hazard_detect u_hazard (
      .D_icode  (D_icode),
      .d_srcA   (d_srcA),
      .d_srcB   (d_srcB),
      .E_icode  (E_icode),
      .E_dstM   (E_dstM),
      .e_cnd    (e_cnd),
      .M_icode  (M_icode),
      .m_stat   (m_stat),
      .W_stat   (W_stat),
      .load_use (load_use),
      .mispred  (mispred),
      .ret_pend (ret_pend),
      .exc      (exc)
   );

   // State, flush counter and captured halt status
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= INIT;
         flush_cnt_q <= '0;
         halt_stat_q <= STAT_AOK;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         halt_stat_q <= halt_stat_d;
      end
   end

   // Next state plus per-stage controls; INIT values double as reset values
   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      halt_stat_d = halt_stat_q;
      F_stall     = 1'b1;
      D_stall     = 1'b0;
      D_bubble    = 1'b1;
      E_bubble    = 1'b1;
      M_bubble    = 1'b1;
      W_stall     = 1'b0;
      W_bubble    = 1'b1;
      set_cc      = 1'b0;
      halted      = 1'b0;
      unique case (state_q)
         INIT: begin
            flush_cnt_d = flush_cnt_q + 1'b1;
            if (flush_cnt_q == FLUSH_LAST) begin
               state_d = RUN;
            end
         end
         RUN: begin
            F_stall  = load_use | ret_pend;
            D_stall  = load_use;
            // Mispredict wins in decode; load-use keeps the ret bubble out of a stalled D
            D_bubble = mispred | (ret_pend & ~load_use);
            E_bubble = mispred | load_use;
            M_bubble = exc;
            W_stall  = (W_stat != STAT_AOK);
            W_bubble = 1'b0;
            set_cc   = (E_icode == I_OPQ) && !exc;
            if (W_stat != STAT_AOK) begin
               state_d     = HALTED;
               halt_stat_d = W_stat;
            end
         end
         HALTED: begin
            F_stall  = 1'b1;
            D_stall  = 1'b1;
            D_bubble = 1'b0;
            E_bubble = 1'b0;
            M_bubble = 1'b0;
            W_stall  = 1'b1;
            W_bubble = 1'b0;
            halted   = 1'b1;
         end
         default: begin
            state_d = INIT;
         end
      endcase
   end

   assign halt_stat = halt_stat_q;

`ifdef PIPE_CTRL_PERF_EN
   // Performance counters advance only while running, wrapping naturally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_cnt  <= '0;
         stall_cnt  <= '0;
         bubble_cnt <= '0;
      end else if (state_q == RUN) begin
         cycle_cnt <= cycle_cnt + 1'b1;
         if (F_stall) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
         if (D_bubble || E_bubble) begin
            bubble_cnt <= bubble_cnt + 1'b1;
         end
      end
   end
`else
   assign cycle_cnt  = '0;
   assign stall_cnt  = '0;
   assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl with hand-computed control vectors.
// Latency: checks combinational outputs 1-2 time units after each rising edge.
// Backpressure: not applicable; PIPE_CTRL_PERF_EN selects expected counter values.
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
   logic        e_cnd;
   logic [1:0]  m_stat, W_stat;
   logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble;
   logic        W_stall, W_bubble, set_cc, halted;
   logic [1:0]  halt_stat;
   logic [31:0] cycle_cnt, stall_cnt, bubble_cnt;

   int checks = 0;
   int errors = 0;

   // Control vector order: F_stall D_stall D_bubble E_bubble M_bubble W_stall W_bubble set_cc halted
   localparam logic [8:0] V_INIT  = 9'b1_0_1_1_1_0_1_0_0;
   localparam logic [8:0] V_IDLE  = 9'b0_0_0_0_0_0_0_0_0;
   localparam logic [8:0] V_LU    = 9'b1_1_0_1_0_0_0_0_0;
   localparam logic [8:0] V_MISP  = 9'b0_0_1_1_0_0_0_0_0;
   localparam logic [8:0] V_RET   = 9'b1_0_1_0_0_0_0_0_0;
   localparam logic [8:0] V_OPQ   = 9'b0_0_0_0_0_0_0_1_0;
   localparam logic [8:0] V_MEXC  = 9'b0_0_0_0_1_0_0_0_0;
   localparam logic [8:0] V_WEXC  = 9'b0_0_0_0_1_1_0_0_0;
   localparam logic [8:0] V_HALT  = 9'b1_1_0_0_0_1_0_0_1;

`ifdef PIPE_CTRL_PERF_EN
   localparam int EXP_CYC = 10, EXP_STL = 2, EXP_BUB = 3;
`else
   localparam int EXP_CYC = 0, EXP_STL = 0, EXP_BUB = 0;
`endif

   pipe_ctrl #(.FLUSH_CYCLES(5), .CNT_W(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .D_icode    (D_icode),
      .d_srcA     (d_srcA),
      .d_srcB     (d_srcB),
      .E_icode    (E_icode),
      .E_dstM     (E_dstM),
      .e_cnd      (e_cnd),
      .M_icode    (M_icode),
      .m_stat     (m_stat),
      .W_stat     (W_stat),
      .F_stall    (F_stall),
      .D_stall    (D_stall),
      .D_bubble   (D_bubble),
      .E_bubble   (E_bubble),
      .M_bubble   (M_bubble),
      .W_stall    (W_stall),
      .W_bubble   (W_bubble),
      .set_cc     (set_cc),
      .halted     (halted),
      .halt_stat  (halt_stat),
      .cycle_cnt  (cycle_cnt),
      .stall_cnt  (stall_cnt),
      .bubble_cnt (bubble_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [8:0] ctl();
      return {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, W_bubble, set_cc, halted};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Pipeline full of nops, no hazards
   task automatic idle();
      D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1;
      d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF;
      e_cnd = 1'b0; m_stat = 2'd0; W_stat = 2'd0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reset pulse applied between edges, then walk through the flush window
   task automatic reset_and_flush();
      idle();
      rst_n = 1'b0;
      #2;
      chk("rst_ctl", 32'(ctl()), 32'(V_INIT));
      chk("rst_halt_stat", 32'(halt_stat), 32'd0);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("flush%0d", i), 32'(ctl()), 32'(V_INIT));
         step();
      end
      chk("run_idle", 32'(ctl()), 32'(V_IDLE));
   endtask

   logic [3:0] p_e_icode [10];
   logic [3:0] p_dstm    [10];
   logic [3:0] p_srca    [10];
   logic [8:0] p_exp     [10];

   initial begin
      idle();
      #2;
      chk("rst_cycle_cnt", cycle_cnt, 32'd0);
      reset_and_flush();

      // Load-use: mrmovq writing %rbx, decode reading %rbx
      E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3; #1;
      chk("load_use", 32'(ctl()), 32'(V_LU));
      E_dstM = 4'hF; #1;
      chk("load_use_rnone", 32'(ctl()), 32'(V_IDLE));
      idle(); E_icode = 4'hB; E_dstM = 4'h4; d_srcB = 4'h4; #1;
      chk("load_use_popq_srcB", 32'(ctl()), 32'(V_LU));

      // Not-taken jump
      idle(); E_icode = 4'h7; e_cnd = 1'b0; #1;
      chk("mispred", 32'(ctl()), 32'(V_MISP));
      e_cnd = 1'b1; #1;
      chk("jxx_taken", 32'(ctl()), 32'(V_IDLE));

      // ret walking D -> E -> M
      idle(); D_icode = 4'h9; step();
      chk("ret_in_D", 32'(ctl()), 32'(V_RET));
      idle(); E_icode = 4'h9; step();
      chk("ret_in_E", 32'(ctl()), 32'(V_RET));
      idle(); M_icode = 4'h9; step();
      chk("ret_in_M", 32'(ctl()), 32'(V_RET));

      // Load-use with ret pending in decode: stall wins over bubble
      idle(); D_icode = 4'h9; E_icode = 4'h5; E_dstM = 4'h2; d_srcB = 4'h2; #1;
      chk("load_use_ret", 32'(ctl()), 32'(V_LU));

      idle(); E_icode = 4'h6; #1;
      chk("opq_set_cc", 32'(ctl()), 32'(V_OPQ));

      // Exception path: ADR in M, then in W, then halt
      m_stat = 2'd2; #1;
      chk("opq_m_exc", 32'(ctl()), 32'(V_MEXC));
      step();
      idle(); W_stat = 2'd2; #1;
      chk("w_exc_run", 32'(ctl()), 32'(V_WEXC));
      chk("halt_stat_pre", 32'(halt_stat), 32'd0);
      step();
      chk("halted_ctl", 32'(ctl()), 32'(V_HALT));
      chk("halted_stat", 32'(halt_stat), 32'd2);
      idle(); step(); step();
      chk("halted_sticky", 32'(ctl()), 32'(V_HALT));
      chk("halted_stat_held", 32'(halt_stat), 32'd2);

      // Asynchronous reset out of HALTED, then a counted run
      reset_and_flush();
      chk("halt_stat_cleared", 32'(halt_stat), 32'd0);

      for (int i = 0; i < 10; i++) begin
         p_e_icode[i] = 4'h1; p_dstm[i] = 4'hF; p_srca[i] = 4'hF; p_exp[i] = V_IDLE;
      end
      p_e_icode[1] = 4'h5; p_dstm[1] = 4'h3; p_srca[1] = 4'h3; p_exp[1] = V_LU;
      p_e_icode[3] = 4'hB; p_dstm[3] = 4'h6; p_srca[3] = 4'h6; p_exp[3] = V_LU;
      p_e_icode[5] = 4'h7;                                     p_exp[5] = V_MISP;
      for (int i = 0; i < 10; i++) begin
         idle();
         E_icode = p_e_icode[i]; E_dstM = p_dstm[i]; d_srcA = p_srca[i]; #1;
         chk($sformatf("perf_vec%0d", i), 32'(ctl()), 32'(p_exp[i]));
         step();
      end
      chk("cycle_cnt", cycle_cnt, 32'(EXP_CYC));
      chk("stall_cnt", stall_cnt, 32'(EXP_STL));
      chk("bubble_cnt", bubble_cnt, 32'(EXP_BUB));

      // halt instruction reaches W; the halting cycle is still a RUN cycle
      idle(); W_stat = 2'd1; step();
      chk("hlt_ctl", 32'(ctl()), 32'(V_HALT));
      chk("hlt_stat", 32'(halt_stat), 32'd1);
      idle(); step(); step(); step();
      chk("cycle_cnt_frozen", cycle_cnt, 32'(EXP_CYC == 0 ? 0 : EXP_CYC + 1));
      chk("stall_cnt_frozen", stall_cnt, 32'(EXP_STL));
      chk("bubble_cnt_frozen", bubble_cnt, 32'(EXP_BUB));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
